// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer with CDB completion, operand lookup and flush.
module reorder_buffer #(
   parameter int ROB_DEPTH = 8,
   parameter int DATA_WIDTH = 32,
   localparam int TW = $clog2(ROB_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dispatch_valid,
   output logic                  dispatch_ready,
   input  logic [31:0]           dispatch_inst,
   input  logic [31:0]           dispatch_pc,
   input  logic [4:0]            dispatch_rd,
   output logic [TW-1:0]         dispatch_tag,
   input  logic                  cdb_valid,
   input  logic [TW-1:0]         cdb_tag,
   input  logic [DATA_WIDTH-1:0] cdb_data,
   input  logic [TW-1:0]         q1_tag,
   input  logic [TW-1:0]         q2_tag,
   output logic                  q1_ready,
   output logic                  q2_ready,
   output logic [DATA_WIDTH-1:0] q1_data,
   output logic [DATA_WIDTH-1:0] q2_data,
   output logic                  commit_valid,
   output logic [TW-1:0]         commit_tag,
   output logic [4:0]            commit_rd,
   output logic [DATA_WIDTH-1:0] commit_data,
   output logic [31:0]           commit_pc,
   output logic [31:0]           commit_inst,
   input  logic                  flush,
   output logic [TW:0]           count
);
   logic                  r_busy  [ROB_DEPTH];
   logic                  r_ready [ROB_DEPTH];
   logic [31:0]           r_inst  [ROB_DEPTH];
   logic [31:0]           r_pc    [ROB_DEPTH];
   logic [4:0]            r_rd    [ROB_DEPTH];
   logic [DATA_WIDTH-1:0] r_data  [ROB_DEPTH];
   logic [TW:0]           r_head, r_tail;
   logic [TW-1:0]         w_hidx, w_tidx;
   logic                  w_full, w_q1_hit, w_q2_hit;

   assign w_hidx = r_head[TW-1:0];
   assign w_tidx = r_tail[TW-1:0];
   assign w_full = (w_hidx == w_tidx) && (r_head[TW] != r_tail[TW]);
   assign dispatch_ready = !w_full;
   assign dispatch_tag = w_tidx;
   assign count = r_tail - r_head;
   assign commit_valid = r_busy[w_hidx] && r_ready[w_hidx] && !flush;
   assign commit_tag = w_hidx;
   assign commit_rd = r_rd[w_hidx];
   assign commit_data = r_data[w_hidx];
   assign commit_pc = r_pc[w_hidx];
   assign commit_inst = r_inst[w_hidx];

   // a same-cycle broadcast forwards to the lookup before it lands in the entry
   assign w_q1_hit = cdb_valid && (cdb_tag == q1_tag) && r_busy[q1_tag];
   assign w_q2_hit = cdb_valid && (cdb_tag == q2_tag) && r_busy[q2_tag];
   assign q1_ready = r_busy[q1_tag] && (w_q1_hit || r_ready[q1_tag]);
   assign q2_ready = r_busy[q2_tag] && (w_q2_hit || r_ready[q2_tag]);
   assign q1_data = !r_busy[q1_tag] ? '0 : w_q1_hit ? cdb_data : r_data[q1_tag];
   assign q2_data = !r_busy[q2_tag] ? '0 : w_q2_hit ? cdb_data : r_data[q2_tag];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_head <= '0;
         r_tail <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) begin
            r_busy[i] <= 1'b0;
            r_ready[i] <= 1'b0;
            r_data[i] <= '0;
         end
      end else if (flush) begin
         r_head <= '0;
         r_tail <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) begin
            r_busy[i] <= 1'b0;
            r_ready[i] <= 1'b0;
         end
      end else begin
         if (dispatch_valid && !w_full) begin
            r_busy[w_tidx] <= 1'b1;
            r_ready[w_tidx] <= 1'b0;
            r_inst[w_tidx] <= dispatch_inst;
            r_pc[w_tidx] <= dispatch_pc;
            r_rd[w_tidx] <= dispatch_rd;
            r_tail <= r_tail + 1'b1;
         end
         if (cdb_valid && r_busy[cdb_tag]) begin
            r_ready[cdb_tag] <= 1'b1;
            r_data[cdb_tag] <= cdb_data;
         end
         // retirement is ordered last so it wins over a repeat broadcast to the head
         if (commit_valid) begin
            r_busy[w_hidx] <= 1'b0;
            r_ready[w_hidx] <= 1'b0;
            r_head <= r_head + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed checks of reorder_buffer with hand-computed expectations.
module tb_reorder_buffer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        dispatch_valid, dispatch_ready;
   logic [31:0] dispatch_inst, dispatch_pc;
   logic [4:0]  dispatch_rd;
   logic [2:0]  dispatch_tag;
   logic        cdb_valid;
   logic [2:0]  cdb_tag, q1_tag, q2_tag, commit_tag;
   logic [31:0] cdb_data, q1_data, q2_data, commit_data, commit_pc, commit_inst;
   logic        q1_ready, q2_ready, commit_valid, flush;
   logic [4:0]  commit_rd;
   logic [3:0]  count;
   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   reorder_buffer dut (
      .clk(clk), .rst_n(rst_n),
      .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
      .dispatch_inst(dispatch_inst), .dispatch_pc(dispatch_pc),
      .dispatch_rd(dispatch_rd), .dispatch_tag(dispatch_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
      .q1_data(q1_data), .q2_data(q2_data),
      .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
      .commit_data(commit_data), .commit_pc(commit_pc), .commit_inst(commit_inst),
      .flush(flush), .count(count)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      dispatch_valid = 1'b0;
      cdb_valid = 1'b0;
      flush = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic disp(input int k);
      dispatch_valid = 1'b1;
      dispatch_rd = 5'(k % 31 + 1);
      dispatch_pc = 32'h100 + 32'(4 * k);
      dispatch_inst = 32'hA0 + 32'(k);
   endtask

   task automatic bcast(input logic [2:0] t, input logic [31:0] d);
      cdb_valid = 1'b1;
      cdb_tag = t;
      cdb_data = d;
   endtask

   initial begin
      int nd, nc, max_cnt;
      int slot_k [0:127];
      rst_n = 1'b1; q1_tag = 3'd0; q2_tag = 3'd0;
      dispatch_rd = '0; dispatch_pc = '0; dispatch_inst = '0;
      cdb_tag = '0; cdb_data = '0;
      idle();
      do_reset();
      #1;
      chk("rst_dready", dispatch_ready, 1);
      chk("rst_dtag", dispatch_tag, 0);
      chk("rst_count", count, 0);
      chk("rst_cvalid", commit_valid, 0);
      chk("rst_q1", q1_ready, 0);
      chk("rst_q2", q2_ready, 0);

      // out-of-order completion, in-order commit
      for (int i = 0; i < 3; i++) begin
         disp(i);
         #1 chk("d3_tag", dispatch_tag, 64'(i));
         tick();
      end
      idle();
      chk("d3_count", count, 3);
      bcast(3'd1, 32'h22);
      #1 chk("c1_nocommit", commit_valid, 0);
      tick();
      idle();
      chk("c1_after", commit_valid, 0);
      bcast(3'd0, 32'h11);
      #1 chk("c0_nobypass", commit_valid, 0);
      tick();
      idle();
      chk("cm0_valid", commit_valid, 1);
      chk("cm0_tag", commit_tag, 0);
      chk("cm0_data", commit_data, 32'h11);
      chk("cm0_rd", commit_rd, 1);
      chk("cm0_pc", commit_pc, 32'h100);
      chk("cm0_inst", commit_inst, 32'hA0);
      tick();
      chk("cm1_valid", commit_valid, 1);
      chk("cm1_tag", commit_tag, 1);
      chk("cm1_data", commit_data, 32'h22);
      chk("cm1_rd", commit_rd, 2);
      tick();
      chk("cm2_none", commit_valid, 0);
      chk("cm2_count", count, 1);

      // lookup forwarding from the CDB, then from storage
      q1_tag = 3'd2; q2_tag = 3'd3;
      #1 chk("q1_pend", q1_ready, 0);
      bcast(3'd2, 32'hABCD);
      #1;
      chk("q1_fwd_rdy", q1_ready, 1);
      chk("q1_fwd_data", q1_data, 32'hABCD);
      chk("q2_idle_rdy", q2_ready, 0);
      chk("q2_idle_data", q2_data, 0);
      tick();
      idle();
      chk("q1_stored_rdy", q1_ready, 1);
      chk("q1_stored_data", q1_data, 32'hABCD);
      chk("cm2_valid", commit_valid, 1);
      chk("cm2_tag", commit_tag, 2);
      tick();
      chk("drain_count", count, 0);

      // full buffer stalls dispatch
      do_reset();
      for (int i = 0; i < 8; i++) begin
         disp(i);
         tick();
      end
      #1;
      chk("full_dready", dispatch_ready, 0);
      chk("full_count", count, 8);
      tick();
      idle();
      chk("ninth_count", count, 8);
      chk("ninth_dtag", dispatch_tag, 0);
      bcast(3'd0, 32'h77);
      tick();
      idle();
      chk("full_cvalid", commit_valid, 1);
      chk("full_ctag", commit_tag, 0);
      chk("full_still", dispatch_ready, 0);
      tick();
      chk("freed_dready", dispatch_ready, 1);
      chk("freed_count", count, 7);

      // dispatch, broadcast and commit in the same cycle
      bcast(3'd1, 32'h55);
      tick();
      idle();
      chk("sim_cvalid", commit_valid, 1);
      chk("sim_ctag", commit_tag, 1);
      disp(8);
      bcast(3'd2, 32'h66);
      tick();
      idle();
      chk("sim_count", count, 7);
      chk("sim_next_tag", commit_tag, 2);
      chk("sim_next_data", commit_data, 32'h66);

      // flush dominates a ready head and a dispatch
      do_reset();
      for (int i = 0; i < 5; i++) begin
         disp(i);
         tick();
      end
      idle();
      bcast(3'd0, 32'h99);
      tick();
      idle();
      chk("pre_flush_cv", commit_valid, 1);
      flush = 1'b1;
      disp(5);
      #1;
      chk("flush_cv", commit_valid, 0);
      chk("flush_dready", dispatch_ready, 1);
      tick();
      idle();
      chk("flush_count", count, 0);
      chk("flush_dtag", dispatch_tag, 0);
      q1_tag = 3'd0;
      #1 chk("flush_q1", q1_ready, 0);

      // streaming with completion two cycles after dispatch, across two wraps
      do_reset();
      for (int i = 0; i < 128; i++) slot_k[i] = -1;
      nd = 0; nc = 0; max_cnt = 0;
      for (int cy = 0; cy < 100 && nc < 20; cy++) begin
         idle();
         if (nd < 20) disp(nd);
         if (cy >= 2 && slot_k[cy-2] >= 0) bcast(3'(slot_k[cy-2] % 8), 32'h1000 + 32'(slot_k[cy-2]));
         #1;
         if (nd < 20 && dispatch_ready) begin
            slot_k[cy] = nd;
            nd++;
         end
         if (commit_valid) begin
            chk("st_tag", commit_tag, 64'(nc % 8));
            chk("st_data", commit_data, 32'h1000 + 32'(nc));
            nc++;
         end
         if (int'(count) > max_cnt) max_cnt = int'(count);
         tick();
      end
      idle();
      chk("st_ncommit", 64'(nc), 20);
      chk("st_maxcnt_le8", 64'(max_cnt <= 8), 1);
      chk("st_empty", count, 0);

      // reset mid-operation discards in-flight entries
      for (int i = 0; i < 4; i++) begin
         disp(i);
         tick();
      end
      idle();
      bcast(3'd1, 32'h44);
      tick();
      idle();
      chk("pre_rst_count", count, 4);
      rst_n = 1'b0;
      disp(4);
      tick();
      rst_n = 1'b1;
      idle();
      chk("mr_dready", dispatch_ready, 1);
      chk("mr_dtag", dispatch_tag, 0);
      chk("mr_count", count, 0);
      chk("mr_cvalid", commit_valid, 0);
      q1_tag = 3'd1; q2_tag = 3'd0;
      bcast(3'd1, 32'h88);
      #1;
      chk("mr_q1", q1_ready, 0);
      chk("mr_q2", q2_ready, 0);
      tick();
      idle();
      chk("mr_old_cv", commit_valid, 0);
      chk("mr_old_q1", q1_ready, 0);
      chk("mr_old_count", count, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter ROB_DEPTH, default 8: number of entries; power of two, at least 2; tag width TW = log2(ROB_DEPTH).
REQ-002 Parameter DATA_WIDTH, default 32: result width.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 dispatch_valid  input  1  decode presents an instruction to allocate.
REQ-006 dispatch_ready  output  1  an entry is free.
REQ-007 dispatch_inst  input  32  instruction word.
REQ-008 dispatch_pc  input  32  PC of the instruction.
REQ-009 dispatch_rd  input  5  architectural destination; 0 means no write.
REQ-010 dispatch_tag  output  TW  tag that the current dispatch receives (the tail index).
REQ-011 cdb_valid  input  1  a result broadcast is present.
REQ-012 cdb_tag  input  TW  entry that the broadcast completes.
REQ-013 cdb_data  input  DATA_WIDTH  result value.
REQ-014 q1_tag, q2_tag  input  TW each  operand lookup tags from the reservation stations.
REQ-015 q1_ready, q2_ready  output  1 each  the looked-up entry holds a result.
REQ-016 q1_data, q2_data  output  DATA_WIDTH each  the looked-up result.
REQ-017 commit_valid  output  1  the head entry retires this cycle.
REQ-018 commit_tag  output  TW  index of the head entry.
REQ-019 commit_rd, commit_data, commit_pc, commit_inst  output  5/DATA_WIDTH/32/32  fields of the head entry.
REQ-020 flush  input  1  discard every entry.
REQ-021 count  output  TW+1  number of occupied entries.

Function
REQ-022 Storage: circular array. Each entry holds busy, ready, inst, pc, rd and data.
REQ-023 Pointers: head and tail pointers, each TW+1 bits wide, where the MSB is a wrap bit.
  - Empty when the pointers are equal.
  - Full when the index bits are equal and the wrap bits differ.
REQ-024 dispatch_ready = !full, combinational. It does not depend on a same-cycle commit, so a full ROB always stalls dispatch for one cycle.
REQ-025 dispatch_tag = tail index at all times.
REQ-026 Allocation: when dispatch_valid && dispatch_ready, on the edge:
  - write the entry at the tail with busy=1, ready=0;
  - increment tail modulo 2*ROB_DEPTH.
REQ-027 Dispatch while full is ignored: no state change.
REQ-028 Completion: when cdb_valid is high and entry[cdb_tag].busy = 1, on the edge set ready=1 and data=cdb_data.
  - A broadcast to a non-busy entry is ignored.
  - A repeat broadcast to an already-ready entry overwrites its data.
REQ-029 Commit: commit_valid = entry[head].busy && entry[head].ready && !flush, combinational.
  - The commit_* outputs reflect the head entry.
  - On a commit edge: clear busy and ready, increment head.
  - At most one commit per cycle.
REQ-030 A result is observable on commit no earlier than the cycle after its CDB broadcast; there is no CDB-to-commit bypass.
REQ-031 Operand lookup, qN (N = 1, 2), combinational, in priority order:
  - if cdb_valid && cdb_tag == qN_tag && entry[qN_tag].busy: ready=1, data=cdb_data;
  - else: ready=entry.ready, data=entry.data.
  - When not busy: ready=0, data=0.
REQ-032 Dispatch, CDB and commit may all occur in the same cycle; each takes effect independently.
  - Count changes by +1, 0 or -1 accordingly.
REQ-033 Priority: flush > all other events.
  - When flush is high, on the edge: head=tail=0, all busy/ready=0.
  - Dispatch, CDB and commit are discarded that cycle; dispatch_ready and commit_valid are still computed normally except that commit_valid = 0.
REQ-034 Pointer wrap: after ROB_DEPTH allocations the tail index returns to 0 and the wrap bit toggles. Full and empty detection stay correct across any number of wraps.
REQ-035 count = tail - head, modulo 2*ROB_DEPTH, interpreted as an unsigned TW+1-bit value; range 0..ROB_DEPTH.

Reset
REQ-036 While rst_n is low at an edge: head=0, tail=0, all entries busy=0, ready=0, data=0.
REQ-037 Reset overrides flush, dispatch, CDB and commit.
REQ-038 Outputs after reset:
  - dispatch_ready=1, dispatch_tag=0, count=0;
  - commit_valid=0, q1_ready=q2_ready=0.
REQ-039 Reset asserted mid-operation discards all in-flight entries within one cycle.

Verification
REQ-040 Dispatch 3 instructions (rd=1,2,3); CDB tag 1 data 0x22; then tag 0 data 0x11 -> no commit until the tag-0 broadcast; in the next cycle commit tag 0 (0x11), then the following cycle commit tag 1 (0x22); tag 2 stays uncommitted.
REQ-041 Fill 8 entries with no CDB -> dispatch_ready=0 and count=8; a 9th dispatch is ignored; CDB tag 0 -> commit the next cycle; dispatch_ready=1 the cycle after the commit.
REQ-042 Dispatch 20 instructions, each completed two cycles later -> all commit in order with tags 0..7,0..7,0..3; count never exceeds 8.
REQ-043 q1_tag=2 with cdb_valid, cdb_tag=2, data 0xABCD in the same cycle -> q1_ready=1, q1_data=0xABCD combinationally; the same lookup on the next cycle still returns 0xABCD.
REQ-044 5 entries busy, head ready, flush asserted -> commit_valid=0 that cycle; the next cycle count=0, dispatch_tag=0.
REQ-045 rst_n low for one cycle while 4 entries are busy -> on the next cycle all outputs are at reset values; a broadcast to an old tag is ignored.
